gan_frame_serializer: RTL and testbench
=======================================

Name: gan_frame_serializer

Overview:
- Sink-side companion to the GAN top level.
- Tracks each latent pair issued to the generator/discriminator pipeline. Captures the 9 pixel words when they emerge from the generator and the discriminator score when it emerges later.
- Buffers complete frames and streams each frame out as 10 words over a valid/ready interface for the host/testbench readback path.

Parameters:
- WIDTH, 32, data word width (signed, matches pipeline datapath)
- LAT_G, 3, cycles from in_valid to the matching pixel words at pix_bus
- LAT_D, 5, cycles from in_valid to the matching score at disc; legal range 1 <= LAT_G < LAT_D
- DEPTH, 4, frame buffer entries; power of 2, >= 2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (rst=0 resets)
- in_valid  input  1  high in the cycle a latent pair is presented to the pipeline input register
- in_tag  input  1  per-frame tag (the choice bit), sampled with in_valid
- pix_bus  input  9*WIDTH  pixel_1x1 in [WIDTH-1:0] through pixel_3x3 in the MSBs, row-major
- disc  input  WIDTH  discriminator score
- m_data  output  WIDTH  serialized frame word
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accept
- m_last  output  1  high on word 9 (score)
- m_tag  output  1  tag of the frame being sent
- overflow  output  1  sticky: a frame was dropped
- drop_count  output  8  dropped frames, saturates at 255

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, m_tag=0, overflow=0, drop_count=0, all tokens and entries invalid, all pointers 0, FSM=IDLE.
- Token pipe:
  - LAT_D-stage shift register, advancing every cycle. Each stage holds {valid, tag, kept}.
  - in_valid=1 enters {1, in_tag, 0} at stage 0.
  - The token reaching age LAT_G (the cycle LAT_G after in_valid) is the pixel token. The token reaching age LAT_D is the score token.
- Pixel capture (pixel token valid):
  - If the allocated count < DEPTH: write pix_bus and tag into entry wr_ptr, mark it allocated/incomplete, wr_ptr++, set the token's kept=1.
  - Otherwise: drop the frame, kept stays 0, set overflow, drop_count++ (saturating).
  - Allocation compares against the count before any same-cycle free, so a full buffer drops even when the head frame completes its send in the same cycle.
- Score capture (score token valid and kept=1):
  - Write disc into entry dsc_ptr, mark it complete, dsc_ptr++.
  - kept=0 tokens are ignored, so a dropped frame never consumes a score slot.
- Output FSM:
  - IDLE: if entry rd_ptr is complete, go to SEND with idx=0. m_valid=0 in IDLE.
  - SEND: m_valid=1, m_data=word[idx] with idx 0..8 = pixels 1x1..3x3 and idx 9 = score. m_tag = entry tag. m_last=(idx==9).
  - On m_valid&&m_ready with idx<9: idx++.
  - On m_valid&&m_ready with idx==9: free the entry, rd_ptr++, return to IDLE.
  - Every frame therefore ends with one bubble cycle.
  - m_data, m_last and m_tag hold stable while m_valid=1 and m_ready=0.
- Latency: in_valid in cycle 0 -> first word m_valid=1 in cycle LAT_D+2 (m_ready held 1). One frame takes 10 cycles plus 1 bubble.
- Pointers and count:
  - All pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Allocated count is log2(DEPTH)+1 bits; +1 on allocate, -1 on free, net 0 when both happen in the same cycle.
- Back-to-back in_valid is legal every cycle. Frames beyond buffer capacity drop in arrival order. Frames are never reordered.
- Reset mid-operation: all state clears asynchronously. m_valid falls immediately. A partially sent frame is discarded and in-flight tokens are lost.
- Fixed word count: no frames are partial on the output side; exactly 10 beats per frame.

Test Plan:
- Single frame, LAT_G=3, LAT_D=5, m_ready=1:
  - Stimulus: in_valid at cycle 0 with tag=1; pix_bus words 1..9 at cycle 3; disc=0x100 at cycle 5.
  - Required: m_valid rises at cycle 7; beats 1,2,...,9,0x100; m_last only on the 10th beat; m_tag=1 throughout; m_valid=0 at cycle 17.
- Backpressure:
  - Stimulus: same frame, m_ready=0 for cycles 7-9, then toggling 1/0.
  - Required: word 1 held through cycles 7-9; exactly 10 accepted beats in order; no word repeated or skipped.
- Overflow, DEPTH=4:
  - Stimulus: 6 consecutive in_valid pulses with m_ready=0.
  - Required: frames 0-3 buffered; frames 4 and 5 dropped; overflow=1; drop_count=2.
  - Then raise m_ready: exactly 40 beats, frame 0's score first paired with frame 0's pixels, and no stale scores from frames 4/5.
- Full and free in the same cycle:
  - Stimulus: buffer full, a pixel token arrives on the cycle frame 0's last beat is accepted.
  - Required: the new frame is dropped; drop_count increments; count goes from 4 to 3.
- Reset mid-send:
  - Stimulus: assert rst=0 after beat 4 of a frame.
  - Required: m_valid=0 immediately; after release, no residual output until a fresh in_valid; that frame comes out with correct latency.
- Wrap-around:
  - Stimulus: 20 frames at one frame per 12 cycles with distinct data.
  - Required: all 200 beats correct in order; overflow=0.

Source files
------------

// File: rtl/gan_frame_serializer.sv
// Pairs generator pixels with the later discriminator score per latent pair and replays each frame as 10 beats.
// Latency in_valid -> first beat LAT_D+2 cycles, 10 beats + 1 idle per frame; m_ready low holds the beat, a full buffer drops new frames.
module gan_frame_serializer #(
    parameter int WIDTH = 32,
    parameter int LAT_G = 3,
    parameter int LAT_D = 5,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_tag,
    input  logic [9*WIDTH-1:0] pix_bus,
    input  logic [WIDTH-1:0]   disc,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               m_tag,
    output logic               overflow,
    output logic [7:0]         drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    logic [LAT_D-1:0]   r_tok_vld;
    logic [LAT_D-1:0]   r_tok_kept;
    logic [LAT_G-1:0]   r_tok_tag;
    logic [9*WIDTH-1:0] r_pix [DEPTH];
    logic [WIDTH-1:0]   r_score [DEPTH];
    logic [DEPTH-1:0]   r_etag;
    logic [DEPTH-1:0]   r_cmp;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_dsc_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;
    state_t             r_state;
    logic [3:0]         r_idx;

    logic               w_pix_tok;
    logic               w_alloc;
    logic               w_drop;
    logic               w_score;
    logic               w_free;
    logic [LAT_D-1:0]   w_kept_next;
    logic [3:0]         w_nidx;
    logic [WIDTH-1:0]   w_next_word;

    // Room is judged on the count before any same-cycle free.
    assign w_pix_tok = r_tok_vld[LAT_G-1];
    assign w_alloc   = w_pix_tok && (r_count < FULL);
    assign w_drop    = w_pix_tok && !(r_count < FULL);
    assign w_score   = r_tok_vld[LAT_D-1] && r_tok_kept[LAT_D-1];
    assign w_free    = (r_state == SEND) && m_ready && (r_idx == 4'd9);

    always_comb begin
        w_kept_next        = {r_tok_kept[LAT_D-2:0], 1'b0};
        w_kept_next[LAT_G] = w_alloc;
    end

    always_comb begin
        w_nidx      = (r_state == SEND) ? r_idx + 4'd1 : 4'd0;
        w_next_word = r_score[r_rd_ptr];
        if (w_nidx < 4'd9)
            w_next_word = r_pix[r_rd_ptr][w_nidx*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_pix[r_wr_ptr]  <= pix_bus;
            r_etag[r_wr_ptr] <= r_tok_tag[LAT_G-1];
        end
        if (w_score)
            r_score[r_dsc_ptr] <= disc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tok_vld  <= '0;
            r_tok_kept <= '0;
            r_tok_tag  <= '0;
            r_cmp      <= '0;
            r_wr_ptr   <= '0;
            r_dsc_ptr  <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            r_tok_vld  <= {r_tok_vld[LAT_D-2:0], in_valid};
            r_tok_kept <= w_kept_next;
            r_tok_tag[0] <= in_tag;
            for (int i = 1; i < LAT_G; i++)
                r_tok_tag[i] <= r_tok_tag[i-1];
            if (w_free) begin
                r_cmp[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_alloc) begin
                r_cmp[r_wr_ptr] <= 1'b0;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_score) begin
                r_cmp[r_dsc_ptr] <= 1'b1;
                r_dsc_ptr        <= r_dsc_ptr + PW'(1);
            end
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
            case ({w_alloc, w_free})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_tag   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_cmp[r_rd_ptr]) begin
                        r_state <= SEND;
                        r_idx   <= 4'd0;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        m_data  <= w_next_word;
                        m_tag   <= r_etag[r_rd_ptr];
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (r_idx == 4'd9) begin
                            r_state <= IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end else begin
                            r_idx  <= w_nidx;
                            m_data <= w_next_word;
                            m_last <= (w_nidx == 4'd9);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gan_frame_serializer.sv
module tb_gan_frame_serializer;
    localparam int W  = 32;
    localparam int LG = 3;
    localparam int LD = 5;
    localparam int DP = 4;

    typedef struct packed { logic tag; logic [9:0][W-1:0] w; } frame_t;
    typedef struct packed { logic [31:0] id; logic cmp; frame_t f; } entry_t;
    typedef struct packed { logic v; logic rdy; logic ev; logic [W-1:0] ed; logic el; } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_tag = 1'b0;
    logic [9*W-1:0] pix_bus = '0;
    logic [W-1:0]   disc = '0;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic           m_last;
    logic           m_tag;
    logic           overflow;
    logic [7:0]     drop_count;

    gan_frame_serializer #(.WIDTH(W), .LAT_G(LG), .LAT_D(LD), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag),
        .pix_bus(pix_bus), .disc(disc), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .m_tag(m_tag),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int     nvec = 0;
    int     nfail = 0;
    int     cyc = 0;
    int     beats = 0;
    bit     fixed = 0;
    frame_t fr[int];
    entry_t q[$];
    bit     sending = 0;
    int     b = 0;
    bit     m_ovf = 0;
    int     m_drops = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: a queue of buffered frames, an output beat index, and drop accounting.
    task automatic model_step();
        bit head_rdy;
        chk("m_valid", m_valid, sending);
        if (sending) begin
            chk("m_data", m_data, q[0].f.w[b]);
            chk("m_last", m_last, b == 9);
            chk("m_tag", m_tag, q[0].f.tag);
        end
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        if (m_valid && m_ready) beats++;
        if (fr.exists(cyc - LG)) begin
            if (q.size() < DP) begin
                entry_t e;
                e.id = 32'(cyc - LG);
                e.cmp = 1'b0;
                e.f = fr[cyc - LG];
                q.push_back(e);
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        head_rdy = (q.size() > 0) && q[0].cmp;
        if (fr.exists(cyc - LD)) begin
            for (int i = 0; i < q.size(); i++)
                if (q[i].id == 32'(cyc - LD)) q[i].cmp = 1'b1;
            fr.delete(cyc - LD);
        end
        if (sending) begin
            if (m_ready) begin
                if (b == 9) begin
                    q.delete(0);
                    sending = 0;
                end else begin
                    b++;
                end
            end
        end else if (head_rdy) begin
            sending = 1;
            b = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_step();
    end

    task automatic tick(input bit v, input bit t, input bit r);
        frame_t f;
        logic [9:0][W-1:0] w;
        @(posedge clk);
        #1;
        cyc++;
        in_valid = v;
        in_tag = t;
        m_ready = r;
        if (v) begin
            f.tag = t;
            for (int k = 0; k < 10; k++)
                f.w[k] = fixed ? ((k < 9) ? W'(k + 1) : W'(32'h100)) : W'($urandom);
            fr[cyc] = f;
        end
        for (int k = 0; k < 10; k++) w[k] = W'($urandom);
        if (fr.exists(cyc - LG)) begin
            f = fr[cyc - LG];
            for (int k = 0; k < 9; k++) w[k] = f.w[k];
        end
        if (fr.exists(cyc - LD)) begin
            f = fr[cyc - LD];
            w[9] = f.w[9];
        end
        pix_bus = w[8:0];
        disc = w[9];
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("reset m_valid", m_valid, 0);
        chk("reset m_last", m_last, 0);
        chk("reset overflow", overflow, 0);
        chk("reset drop_count", drop_count, 0);
        fr.delete();
        q.delete();
        sending = 0;
        b = 0;
        m_ovf = 0;
        m_drops = 0;
        repeat (2) tick(0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        vec_t tbl[18];
        int   b0;
        int   k0;

        for (int k = 0; k < 18; k++) begin
            tbl[k].v   = (k == 0);
            tbl[k].rdy = 1'b1;
            tbl[k].ev  = (k >= 7 && k <= 16);
            tbl[k].ed  = (k >= 7 && k <= 15) ? W'(k - 6) : ((k == 16) ? W'(32'h100) : W'(0));
            tbl[k].el  = (k == 16);
        end

        repeat (2) tick(0, 0, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_last", m_last, 0);
        chk("rst m_data", m_data, 0);
        chk("rst m_tag", m_tag, 0);
        chk("rst overflow", overflow, 0);
        chk("rst drop_count", drop_count, 0);
        rst = 1'b1;

        // single frame, fixed data, exact cycle-by-cycle expectations
        fixed = 1;
        for (int k = 0; k < 18; k++) begin
            tick(tbl[k].v, 1, tbl[k].rdy);
            @(negedge clk);
            chk("tbl m_valid", m_valid, tbl[k].ev);
            if (tbl[k].ev) begin
                chk("tbl m_data", m_data, tbl[k].ed);
                chk("tbl m_last", m_last, tbl[k].el);
                chk("tbl m_tag", m_tag, 1);
            end
        end

        // backpressure: stall cycles 7-9, then alternate ready
        b0 = beats;
        for (int k = 0; k < 32; k++) begin
            tick(k == 0, 0, (k < 7) ? 1'b1 : ((k <= 9) ? 1'b0 : k[0]));
            @(negedge clk);
            if (k >= 7 && k <= 9) chk("stall hold", m_data, 1);
        end
        chk("stall beats", beats - b0, 10);

        // overflow: 6 frames into a 4-deep buffer with no drain
        do_reset();
        fixed = 0;
        for (int k = 0; k < 6; k++) tick(1, k[0], 0);
        repeat (10) tick(0, 0, 0);
        chk("ovf flag", overflow, 1);
        chk("ovf drop_count", drop_count, 2);
        b0 = beats;
        repeat (50) tick(0, 0, 1);
        @(negedge clk);
        chk("ovf beats", beats - b0, 40);

        // full buffer: new pixel token lands on the head's final accepted beat
        do_reset();
        b0 = beats;
        for (int k = 0; k < 60; k++) tick(k < 4 || k == 13, 1, 1);
        @(negedge clk);
        chk("full-free drop", drop_count, 1);
        chk("full-free beats", beats - b0, 40);

        // reset during beat 5 of a frame
        do_reset();
        fixed = 1;
        for (int k = 0; k < 12; k++) tick(k == 0, 1, 1);
        do_reset();
        repeat (20) tick(0, 0, 1);
        k0 = 0;
        tick(1, 0, 1);
        for (int k = 1; k <= 20 && k0 == 0; k++) begin
            tick(0, 0, 1);
            @(negedge clk);
            if (m_valid) k0 = k;
        end
        chk("post-reset latency", k0, 7);
        repeat (15) tick(0, 0, 1);

        // wrap-around: 20 spaced frames
        fixed = 0;
        b0 = beats;
        for (int k = 0; k < 260; k++) tick((k % 12) == 0 && k < 240, 1'($urandom % 2), 1);
        @(negedge clk);
        chk("wrap beats", beats - b0, 200);
        chk("wrap overflow", overflow, 0);

        // random traffic and ready, heavy enough to saturate drop_count
        for (int k = 0; k < 3000; k++)
            tick(($urandom % 3) == 0, 1'($urandom % 2), ($urandom % 4) != 0);
        repeat (400) tick(0, 0, 1);
        @(negedge clk);
        chk("drained m_valid", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
